// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcode, field-position and FSM-state definitions for the MIPS pipeline control
package pipe_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    typedef logic [0:0] hz_state_t;
    localparam hz_state_t RUN     = 1'b0;
    localparam hz_state_t LU_WAIT = 1'b1;
    // opcodes whose rt field is a source operand
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    // next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        count_d = (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
        count_d = clear_i ? '0 : count_d;
    end

    // count register
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and data-memory freeze control beside the ID stage
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int INSTR_W    = 32,
    parameter int LU_STALL   = 1,
    parameter bit PRECISE_RT = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               idex_memread_i,
    input  logic [REG_AW-1:0]  idex_rt_i,
    input  logic [INSTR_W-1:0] ifid_instr_i,
    input  logic               branch_taken_i,
    input  logic               dmem_stall_i,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               idex_bubble_o,
    output logic               ifid_flush_o,
    output logic               pipe_freeze_o,
    output logic [CNT_W-1:0]   stall_cycles_o
);
    localparam logic [3:0] LU_INIT = 4'(LU_STALL - 1);

    hz_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       uses_rt, hit, stall;
    logic       unused_bits;

    assign unused_bits = ^ifid_instr_i[15:0];

    // load-use hit decode and output priority: reset, then freeze, then stall, then flush
    always_comb begin
        uses_rt       = !PRECISE_RT || reads_rt(ifid_instr_i[OP_MSB:OP_LSB]);
        hit           = idex_memread_i && (idex_rt_i != '0) &&
                        ((idex_rt_i == ifid_instr_i[RS_MSB:RS_LSB]) ||
                         (uses_rt && idex_rt_i == ifid_instr_i[RT_MSB:RT_LSB]));
        stall         = !dmem_stall_i && (state_q == LU_WAIT || hit);
        pc_write_o    = rst_i || !(dmem_stall_i || stall);
        ifid_write_o  = pc_write_o;
        idex_bubble_o = !rst_i && stall;
        ifid_flush_o  = !rst_i && !dmem_stall_i && !stall && branch_taken_i;
        pipe_freeze_o = !rst_i && dmem_stall_i;
    end

    // FSM next state: freeze holds everything, a multi-cycle hit enters LU_WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!dmem_stall_i) begin
            if (state_q == RUN && hit && LU_STALL > 1) begin
                state_d = LU_WAIT;
                cnt_d   = LU_INIT;
            end else if (state_q == LU_WAIT) begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RUN : LU_WAIT;
            end
        end
    end

    // state and remaining-stall registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (!pc_write_o),
        .count_o (stall_cycles_o)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl across four parameter sets sharing one stimulus
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        memread;
    logic [4:0]  rt;
    logic [31:0] instr;
    logic        br;
    logic        dms;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] ADD_RS2 = 32'h00441820;
    localparam logic [31:0] ADD_RT2 = 32'h00821820;
    localparam logic [31:0] LW_RT2  = 32'h8CE20000;

    logic pw1, iw1, bb1, fl1, fz1; logic [31:0] sc1;
    logic pw3, iw3, bb3, fl3, fz3; logic [31:0] sc3;
    logic pw0, iw0, bb0, fl0, fz0; logic [31:0] sc0;
    logic pw4, iw4, bb4, fl4, fz4; logic [3:0]  sc4;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL(1), .PRECISE_RT(1'b1)) d1 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(rt), .ifid_instr_i(instr),
        .branch_taken_i(br), .dmem_stall_i(dms), .pc_write_o(pw1), .ifid_write_o(iw1),
        .idex_bubble_o(bb1), .ifid_flush_o(fl1), .pipe_freeze_o(fz1), .stall_cycles_o(sc1));
    hazard_ctrl #(.LU_STALL(3), .PRECISE_RT(1'b1)) d3 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(rt), .ifid_instr_i(instr),
        .branch_taken_i(br), .dmem_stall_i(dms), .pc_write_o(pw3), .ifid_write_o(iw3),
        .idex_bubble_o(bb3), .ifid_flush_o(fl3), .pipe_freeze_o(fz3), .stall_cycles_o(sc3));
    hazard_ctrl #(.LU_STALL(1), .PRECISE_RT(1'b0)) d0 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(rt), .ifid_instr_i(instr),
        .branch_taken_i(br), .dmem_stall_i(dms), .pc_write_o(pw0), .ifid_write_o(iw0),
        .idex_bubble_o(bb0), .ifid_flush_o(fl0), .pipe_freeze_o(fz0), .stall_cycles_o(sc0));
    hazard_ctrl #(.LU_STALL(1), .PRECISE_RT(1'b1), .CNT_W(4)) d4 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(rt), .ifid_instr_i(instr),
        .branch_taken_i(br), .dmem_stall_i(dms), .pc_write_o(pw4), .ifid_write_o(iw4),
        .idex_bubble_o(bb4), .ifid_flush_o(fl4), .pipe_freeze_o(fz4), .stall_cycles_o(sc4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; memread = 1'b1; rt = 5'd2; instr = ADD_RS2; br = 1'b1; dms = 1'b0;
        settle();
        chk("rst_idle_pw", pw1, 1); chk("rst_idle_iw", iw1, 1); chk("rst_idle_bb", bb1, 0);
        chk("rst_idle_fl", fl1, 0);
        step(); step();
        chk("rst_cnt1", sc1, 0); chk("rst_cnt3", sc3, 0); chk("rst_cnt4", sc4, 0);
        rst = 1'b0; br = 1'b0; memread = 1'b0;
        settle();
        chk("run_idle_pw", pw1, 1); chk("run_idle_fz", fz1, 0);
        // single-cycle load-use stall, and the start of a three-cycle one
        memread = 1'b1; rt = 5'd2; instr = ADD_RS2;
        settle();
        chk("lu1_pw", pw1, 0); chk("lu1_iw", iw1, 0); chk("lu1_bb", bb1, 1); chk("lu1_fl", fl1, 0);
        chk("lu3_c1_bb", bb3, 1);
        step();
        memread = 1'b0;
        settle();
        chk("lu1_end_pw", pw1, 1); chk("lu1_end_bb", bb1, 0); chk("lu1_cnt", sc1, 1);
        chk("lu3_c2_pw", pw3, 0); chk("lu3_c2_bb", bb3, 1);
        step();
        chk("lu3_c3_pw", pw3, 0); chk("lu3_c3_iw", iw3, 0);
        step();
        chk("lu3_end_pw", pw3, 1); chk("lu3_cnt", sc3, 3);
        // rt=0 never hits; rt-field match only counts for opcodes that read rt
        memread = 1'b1; rt = 5'd0; instr = ADD_RS2;
        settle();
        chk("rt0_pw", pw1, 1);
        rt = 5'd2; instr = LW_RT2;
        settle();
        chk("lwrt_precise_pw", pw1, 1); chk("lwrt_loose_pw", pw0, 0); chk("lwrt_loose_bb", bb0, 1);
        step();
        memread = 1'b0;
        settle();
        chk("lwrt_cnt1", sc1, 1); chk("lwrt_cnt0", sc0, 2); chk("lwrt_cnt3", sc3, 3);
        memread = 1'b1; instr = ADD_RT2;
        settle();
        chk("addrt_precise_bb", bb1, 1);
        step();
        memread = 1'b0;
        step(); step();
        chk("addrt_cnt1", sc1, 2); chk("addrt_cnt3", sc3, 6); chk("addrt_pw3", pw3, 1);
        // stall suppresses flush; flush follows once the stall clears
        memread = 1'b1; instr = ADD_RS2; br = 1'b1;
        settle();
        chk("br_hit_fl", fl1, 0); chk("br_hit_bb", bb1, 1);
        step();
        memread = 1'b0;
        settle();
        chk("br_after_fl", fl1, 1); chk("br_after_pw", pw1, 1); chk("br_wait3_fl", fl3, 0);
        step();
        br = 1'b0;
        step();
        chk("br_cnt1", sc1, 3); chk("br_cnt3", sc3, 9);
        // freeze for four cycles in the middle of LU_WAIT with two stall cycles left
        memread = 1'b1;
        step();
        memread = 1'b0; dms = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("frz_fz3", fz3, 1); chk("frz_pw3", pw3, 0); chk("frz_bb3", bb3, 0);
            step();
        end
        dms = 1'b0;
        settle();
        chk("frz_rem1_bb", bb3, 1); chk("frz_fz_off", fz3, 0);
        step();
        chk("frz_rem2_bb", bb3, 1);
        step();
        chk("frz_done_pw", pw3, 1); chk("frz_cnt3", sc3, 16); chk("frz_cnt1", sc1, 8);
        // a hit seen only while frozen does not start a stall
        dms = 1'b1; memread = 1'b1; br = 1'b1;
        settle();
        chk("frzhit_bb", bb1, 0); chk("frzhit_fl", fl1, 0); chk("frzhit_fz", fz1, 1);
        step();
        dms = 1'b0; memread = 1'b0;
        settle();
        chk("frzhit_after_pw", pw1, 1); chk("frzhit_cnt1", sc1, 9);
        br = 1'b0;
        // reset during LU_WAIT aborts the stall
        memread = 1'b1;
        step();
        memread = 1'b0; rst = 1'b1;
        settle();
        chk("rstw_forced_pw", pw3, 1); chk("rstw_forced_bb", bb3, 0);
        step();
        rst = 1'b0;
        settle();
        chk("rstw_pw3", pw3, 1); chk("rstw_bb3", bb3, 0); chk("rstw_cnt3", sc3, 0);
        // narrow counter saturates at 15
        dms = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt4", sc4, 15); chk("sat_cnt1", sc1, 20);
        step();
        chk("sat_hold4", sc4, 15);
        dms = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
